transpose_sequencer: RTL

Controller that sequences the matrix-transpose switch network: accepts tile-level requests over a valid/ready handshake, injects one NUM_PE x NUM_PE tile per accepted request, drives the network's global mode bit, and tracks each tile through the fixed-latency pipeline so the consumer sees a tagged output strobe. The network has no stall input. This block therefore enforces credit-based flow control toward the downstream tile buffer. Because the mode bit is shared by every stage, the block drains the pipeline before any mode change.

---
 rtl/transpose_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/transpose_sequencer.sv
// Sequencer for the transpose switch network: credit-gated tile injection, in-flight tracking
// and drain-before-mode-switch. Define TRANSPOSE_SEQ_STATS_EN to add tile/drain-cycle counters.
module transpose_sequencer #(
   parameter int unsigned PIPE_LAT = 8,
   parameter int unsigned CREDITS  = 4,
   parameter int unsigned TAG_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_mode,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_ready,
   output logic             net_load,
   output logic             net_ctrl,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_mode,
   input  logic             credit_ret,
   output logic             busy,
   output logic             credit_err
`ifdef TRANSPOSE_SEQ_STATS_EN
   ,
   output logic [31:0]      stat_tiles,
   output logic [31:0]      stat_drain_cycles
`endif
);

   localparam int unsigned CNT_W = $clog2(CREDITS + 1);
   localparam int unsigned TRK_W = PIPE_LAT * TAG_W;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 net_ctrl_d;
   logic                 pend_mode_q;
   logic                 pend_mode_d;
   logic                 ready_c;
   logic [CNT_W-1:0]     credits_q;
   logic                 credits_full;
   logic                 credit_ok;
   logic                 accept;
   logic                 pipe_empty;

   // Tracker: bit/field 0 is the injection end, the top slot is the network output
   logic [PIPE_LAT-1:0]  trk_valid;
   logic [PIPE_LAT-1:0]  trk_mode;
   logic [TRK_W-1:0]     trk_tag;
   logic [PIPE_LAT:0]    valid_chain;
   logic [PIPE_LAT:0]    mode_chain;
   logic [TRK_W+TAG_W-1:0] tag_chain;

   assign pipe_empty   = (trk_valid == '0);
   assign credits_full = (credits_q == CNT_W'(CREDITS));
   assign credit_ok    = credit_ret && !credits_full;
   assign req_ready    = rst && ready_c;
   assign accept       = req_valid && req_ready;
   assign net_load     = accept;
   assign busy         = !pipe_empty || (state_q != ST_RUN);

   assign valid_chain  = {trk_valid, accept};
   assign mode_chain   = {trk_mode, accept & req_mode};
   assign tag_chain    = {trk_tag, (accept ? req_tag : TAG_W'(0))};

   assign out_valid    = trk_valid[PIPE_LAT-1];
   assign out_mode     = trk_mode[PIPE_LAT-1];
   assign out_tag      = trk_tag[TRK_W-1 -: TAG_W];

   // State, mode and pending-mode registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         net_ctrl    <= 1'b0;
         pend_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         net_ctrl    <= net_ctrl_d;
         pend_mode_q <= pend_mode_d;
      end
   end

   // Next-state and request-ready decode
   always_comb begin
      state_d     = state_q;
      net_ctrl_d  = net_ctrl;
      pend_mode_d = pend_mode_q;
      ready_c     = 1'b0;
      case (state_q)
         ST_RUN: begin
            ready_c = (credits_q != '0) && (req_mode == net_ctrl);
            if (req_valid && (req_mode != net_ctrl)) begin
               pend_mode_d = req_mode;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_d = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            net_ctrl_d = pend_mode_q;
            state_d    = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Downstream credits; a return while already full is dropped and flagged
   always_ff @(posedge clk) begin
      if (!rst) begin
         credits_q  <= CNT_W'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         if (accept && !credit_ok) begin
            credits_q <= credits_q - CNT_W'(1);
         end else if (credit_ok && !accept) begin
            credits_q <= credits_q + CNT_W'(1);
         end
         if (credit_ret && credits_full) begin
            credit_err <= 1'b1;
         end
      end
   end

   // In-flight tracker shifts every cycle; the network has no stall
   always_ff @(posedge clk) begin
      if (!rst) begin
         trk_valid <= '0;
         trk_mode  <= '0;
         trk_tag   <= '0;
      end else begin
         trk_valid <= valid_chain[PIPE_LAT-1:0];
         trk_mode  <= mode_chain[PIPE_LAT-1:0];
         trk_tag   <= tag_chain[TRK_W-1:0];
      end
   end

`ifdef TRANSPOSE_SEQ_STATS_EN
   // Accept count and cycles spent away from RUN, both free-running modulo 2^32
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_tiles        <= 32'd0;
         stat_drain_cycles <= 32'd0;
      end else begin
         if (accept) begin
            stat_tiles <= stat_tiles + 32'd1;
         end
         if (state_q != ST_RUN) begin
            stat_drain_cycles <= stat_drain_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
